irq_ctrl: RTL

Interrupt controller that sequences the datapath's interrupt entry/exit controls (irq_take, irq_save, irq_vector). It latches up to N_IRQ edge-triggered requests, applies mask, global enable and priority, and drives a fixed three-state entry sequence at instruction boundaries. Software configures it through a small 4-register port. Sits beside ctrl_unit, feeding datapath.

---
 rtl/irq_ctrl_pkg.sv | 18 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding,
// configuration register addresses and CTRL register bit positions.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_SAVE = 2'd2
  } irq_state_e;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_PEND = 2'd1;
  localparam logic [1:0] CFG_ISR  = 2'd2;
  localparam logic [1:0] CFG_CTRL = 2'd3;

  localparam int CTRL_GIE = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index of
// the lowest set bit (index 0 = highest priority).
module irq_prio_enc #(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] vec,
  output logic             vld,
  output logic [3:0]       idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    vld = |vec;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches edge-triggered requests, applies mask,
// global enable and priority, and sequences the datapath's entry controls
// (take, then save) at instruction boundaries.
// Optional build macro IRQ_NEST_EN: allows a strictly higher-priority source
// to preempt an in-service handler once software re-enables GIE.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          N_IRQ     = 8,
  parameter logic [15:0] VEC_BASE  = 16'h0100,
  parameter int          VEC_SHIFT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_boundary,
  input  logic             i_reti,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_ad,
  input  logic [15:0]      i_cfg_d,
  output logic [15:0]      o_cfg_q,
  output logic             o_busy,
  output logic             o_irq_take,
  output logic             o_irq_save,
  output logic [15:0]      o_irq_vector,
  output logic [3:0]       o_irq_id
);

  irq_state_e       state_q, state_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] mask_q, isr_q, isr_d;
  logic [N_IRQ-1:0] irq_prev_q;
  logic             gie_q, gie_d;
  logic [3:0]       id_q;

  logic [N_IRQ-1:0] edge_det, cand, take_oh, reti_oh;
  logic             win_vld, isr_vld, isr_ok, eligible;
  logic [3:0]       win_idx, isr_idx;
  logic             wr_mask, wr_pend, wr_ctrl;
  logic             unused_cfg_d;

  assign edge_det = i_irq & ~irq_prev_q;
  assign cand     = pend_q & mask_q;

  assign wr_mask = i_cfg_we && (i_cfg_ad == CFG_MASK);
  assign wr_pend = i_cfg_we && (i_cfg_ad == CFG_PEND);
  assign wr_ctrl = i_cfg_we && (i_cfg_ad == CFG_CTRL);

  // Only the low N_IRQ bits (and bit 0 for CTRL) are meaningful.
  assign unused_cfg_d = ^i_cfg_d;

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_win_enc (
    .vec (cand),
    .vld (win_vld),
    .idx (win_idx)
  );

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_isr_enc (
    .vec (isr_q),
    .vld (isr_vld),
    .idx (isr_idx)
  );

`ifdef IRQ_NEST_EN
  // A strictly higher-priority winner may preempt the lowest in-service source.
  assign isr_ok = !isr_vld || (win_idx < isr_idx);
`else
  // No nesting: nothing may be in service.
  assign isr_ok = !isr_vld;
`endif

  // Decisions always use pre-write, pre-reti register values.
  assign eligible = (state_q == ST_IDLE) && gie_q && win_vld && i_boundary && isr_ok;
  assign o_busy   = eligible || (state_q != ST_IDLE);

  // One-hot strobes for the winner being taken and the ISR bit being retired.
  always_comb begin
    take_oh = '0;
    reti_oh = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      take_oh[i] = eligible && (win_idx == 4'(i));
      reti_oh[i] = i_reti && isr_vld && (isr_idx == 4'(i));
    end
  end

  // Next values of pending, in-service and global-enable state.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~i_cfg_d[N_IRQ-1:0];
    pend_d = (pend_d & ~take_oh) | edge_det;  // a new edge beats a W1C

    isr_d = (isr_q & ~reti_oh) | take_oh;     // reti retires first, then take

    gie_d = gie_q;
    if (i_reti)   gie_d = 1'b1;
    if (wr_ctrl)  gie_d = i_cfg_d[CTRL_GIE];  // software write beats reti
    if (eligible) gie_d = 1'b0;               // entering a handler masks globally
  end

  // Register file, edge-detect history and latched source id.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q     <= '0;
      mask_q     <= '0;
      isr_q      <= '0;
      gie_q      <= 1'b0;
      irq_prev_q <= '0;
      id_q       <= '0;
    end else begin
      pend_q     <= pend_d;
      isr_q      <= isr_d;
      gie_q      <= gie_d;
      irq_prev_q <= i_irq;
      if (wr_mask)  mask_q <= i_cfg_d[N_IRQ-1:0];
      if (eligible) id_q   <= win_idx;
    end
  end

  // Entry sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Entry sequencer: IDLE -> TAKE -> SAVE -> IDLE, one cycle each.
  always_comb begin
    state_d    = state_q;
    o_irq_take = 1'b0;
    o_irq_save = 1'b0;
    case (state_q)
      ST_IDLE: if (eligible) state_d = ST_TAKE;
      ST_TAKE: begin
        o_irq_take = 1'b1;
        state_d    = ST_SAVE;
      end
      ST_SAVE: begin
        o_irq_save = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Configuration read mux; unused upper bits read as zero.
  always_comb begin
    o_cfg_q = '0;
    case (i_cfg_ad)
      CFG_MASK: o_cfg_q = 16'(mask_q);
      CFG_PEND: o_cfg_q = 16'(pend_q);
      CFG_ISR:  o_cfg_q = 16'(isr_q);
      CFG_CTRL: o_cfg_q[CTRL_GIE] = gie_q;
      default:  o_cfg_q = '0;
    endcase
  end

  assign o_irq_vector = VEC_BASE + (16'(id_q) << VEC_SHIFT);
  assign o_irq_id     = id_q;

endmodule
